// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer bundle for sync_fifo_param
// master drives write/read requests; slave is the FIFO itself.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int AW = $clog2(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              wfull;
    logic              rempty;
    logic              almost_full;
    logic              almost_empty;
    logic [AW:0]       count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, wfull, rempty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, wfull, rempty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with count, thresholds and error pulses
// Define FIFO_FWFT_EN for first-word fall-through reads; default is registered read.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_param_if.slave   bus
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [AW:0] LP_AF = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] LP_AE = (AW+1)'(AE_THRESH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       r_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_wfull;
    logic              r_rempty;
    logic              r_almost_full;
    logic              r_almost_empty;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [AW:0]       w_count_nxt;

    // Acceptance uses the registered flags, so a simultaneous pop never frees a slot for a push.
    assign w_wr_acc = bus.wr_en & ~r_wfull;
    assign w_rd_acc = bus.rd_en & ~r_rempty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_data_out     <= '0;
            r_wfull        <= 1'b0;
            r_rempty       <= 1'b1;
            r_almost_full  <= (LP_AF == '0);
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // In fall-through mode this register keeps the last word shown, for display while empty.
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
            end
            r_count        <= w_count_nxt;
            r_wfull        <= (w_count_nxt == (AW+1)'(DEPTH));
            r_rempty       <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= LP_AF);
            r_almost_empty <= (w_count_nxt <= LP_AE);
            r_overflow     <= bus.wr_en & r_wfull;
            r_underflow    <= bus.rd_en & r_rempty;
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_out = r_rempty ? r_data_out : r_mem[r_rd_ptr[AW-1:0]];
`else
    assign bus.data_out = r_data_out;
`endif

    assign bus.wfull        = r_wfull;
    assign bus.rempty       = r_rempty;
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule
